fancy_timer_sched: RTL and testbench

//  Shares one fancy-timer countdown engine (delay+1)*UNIT cycles among NREQ requesters.

---
 rtl/fancy_timer_sched.sv | 103 ++++++++++
 tb/tb_fancy_timer_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fancy_timer_sched.sv
// Shared countdown engine: round-robin grants one requester, counts (delay+1)*UNIT
// cycles, then holds that requester's done until it acknowledges.
module fancy_timer_sched #(
    parameter int NREQ = 4,
    parameter int UNIT = 1000,
    parameter int DW   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] delay,
    input  logic               abort,
    input  logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    output logic [2:0]         cur_id,
    output logic               busy,
    output logic               counting,
    output logic [DW-1:0]      count,
    output logic [NREQ-1:0]    done
);

    localparam int FW = (UNIT > 1) ? $clog2(UNIT) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(UNIT - 1);

    typedef enum logic [1:0] {IDLE, COUNT, WAIT} state_t;

    state_t          state;
    logic [2:0]      rr_ptr;
    logic [DW-1:0]   scount;
    logic [FW-1:0]   fcount;
    logic            found;
    logic [2:0]      winner;
    logic [NREQ-1:0] own_vec;
    logic            own_ack;

    function automatic logic [2:0] next_id(input logic [2:0] id);
        return (int'(id) + 1 >= NREQ) ? 3'd0 : id + 3'd1;
    endfunction

    // First requesting index at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = 3'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign grant    = (state == IDLE && found) ? (NREQ'(1) << winner) : '0;
    assign own_vec  = NREQ'(1) << cur_id;
    assign own_ack  = |(ack & own_vec);
    assign busy     = (state != IDLE);
    assign counting = (state == COUNT);
    assign count    = (state == COUNT) ? scount : '0;
    assign done     = (state == WAIT) ? own_vec : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_id <= '0;
            scount <= '0;
            fcount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur_id <= winner;
                        scount <= delay[int'(winner)*DW +: DW];
                        fcount <= '0;
                        state  <= COUNT;
                    end
                end
                COUNT: begin
                    // Abort wins even in the cycle the count would expire.
                    if (abort) begin
                        state  <= IDLE;
                        rr_ptr <= next_id(cur_id);
                        scount <= '0;
                        fcount <= '0;
                    end else if (fcount == F_LAST) begin
                        fcount <= '0;
                        if (scount == '0) state <= WAIT;
                        else              scount <= scount - 1'b1;
                    end else begin
                        fcount <= fcount + 1'b1;
                    end
                end
                WAIT: begin
                    if (own_ack) begin
                        state  <= IDLE;
                        rr_ptr <= next_id(cur_id);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fancy_timer_sched.sv
// Directed bench for fancy_timer_sched with UNIT=4, NREQ=4; expected grants and
// count sequences are queued when stimulus is driven and popped as the DUT responds.
module tb_fancy_timer_sched;

    localparam int NREQ = 4;
    localparam int UNIT = 4;
    localparam int DW   = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] delay;
    logic               abort;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    grant;
    logic [2:0]         cur_id;
    logic               busy;
    logic               counting;
    logic [DW-1:0]      count;
    logic [NREQ-1:0]    done;

    int passed = 0;
    int total  = 0;
    int gq[$];
    int cq[$];

    fancy_timer_sched #(.NREQ(NREQ), .UNIT(UNIT), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .delay(delay), .abort(abort),
        .ack(ack), .grant(grant), .cur_id(cur_id), .busy(busy),
        .counting(counting), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at negedge+1; drives a request, follows the run through WAIT and acks it.
    task automatic run(input logic [3:0] r, input int id, input int d, input logic [3:0] fack);
        int n;
        req = r;
        delay[id*DW +: DW] = DW'(d);
        gq.push_back(id);
        for (int s = d; s >= 0; s--) repeat (UNIT) cq.push_back(s);
        #1;
        n = 0;
        while (grant == '0 && n < 40) begin @(negedge clk); #1; n++; end
        check("grant", grant, 32'(1) << gq.pop_front());
        @(negedge clk);
        req[id] = 1'b0;
        #1;
        check("cur_id", cur_id, id);
        check("grant_busy", grant, 0);
        n = 0;
        while (counting === 1'b1 && n < 100) begin
            check("count", count, (cq.size() > 0) ? cq.pop_front() : 32'hdead);
            @(negedge clk); #1;
            n++;
        end
        check("count_len", n, (d + 1) * UNIT);
        check("count_q_empty", cq.size(), 0);
        check("wait_done", done, 32'(1) << id);
        check("wait_busy", busy, 1);
        check("wait_count", count, 0);
        if (fack != '0) begin
            ack = fack;
            @(negedge clk); #1;
            check("done_hold", done, 32'(1) << id);
            check("busy_hold", busy, 1);
            ack = '0;
        end
        ack = NREQ'(1) << id;
        @(negedge clk); #1;
        ack = '0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        reset_n = 1'b0; req = '0; delay = '0; abort = 1'b0; ack = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("rst_grant", grant, 0);
        check("rst_count", count, 0);
        check("rst_cur_id", cur_id, 0);
        check("rst_counting", counting, 0);

        // Basic run, then round-robin ordering with two held requests.
        run(4'b0001, 0, 2, 4'b0000);
        run(4'b0101, 2, 1, 4'b0000);
        check("rr_regrant_idle", grant, 4'b0001);
        check("rr_idle_busy", busy, 0);
        run(4'b0001, 0, 1, 4'b0000);

        // Delay extremes, then a foreign ack while requester 1 waits.
        run(4'b0010, 1, 0, 4'b0000);
        run(4'b0100, 2, 15, 4'b0000);
        run(4'b0010, 1, 1, 4'b1000);

        // Abort on the fifth COUNT cycle; rr_ptr then points past requester 0.
        req = 4'b0001; delay[3:0] = 4'd2; #1;
        check("ab_grant", grant, 4'b0001);
        @(negedge clk); req = '0; #1;
        repeat (4) begin check("ab_no_done", done, 0); @(negedge clk); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        req = 4'b0011; delay[7:4] = 4'd0; #1;
        check("ab_rr_grant", grant, 4'b0010);
        @(negedge clk); req = '0; #1;
        repeat (3) @(negedge clk);
        #1;
        check("ab_last_counting", counting, 1);
        check("ab_last_count", count, 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        check("ab_last_busy", busy, 0);
        check("ab_last_done", done, 0);

        // Asynchronous reset mid-COUNT.
        req = 4'b1000; delay[15:12] = 4'd3; #1;
        check("rs_grant", grant, 4'b1000);
        @(negedge clk); req = '0;
        @(posedge clk); #2;
        reset_n = 1'b0; #1;
        check("rs_busy", busy, 0);
        check("rs_counting", counting, 0);
        check("rs_count", count, 0);
        check("rs_done", done, 0);
        check("rs_cur_id", cur_id, 0);
        @(negedge clk);
        reset_n = 1'b1; req = 4'b1001; #1;
        check("rs_rr_grant", grant, 4'b0001);
        @(negedge clk); req = '0; #1;
        check("rs_owner", cur_id, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
